// File: rtl/asg_ch_interp_if.sv
// asg_ch_interp_if: bundles the table-write port, channel configuration and
// channel status of one ASG channel.
//   master : register bank side; drives table writes, trigger and settings,
//            observes dac_o, busy_o, done_o, buf_rpnt_o.
//   slave  : the channel itself.
// Clock and reset are plain module ports, not part of this bundle.
interface asg_ch_interp_if #(
    parameter int DW = 14,
    parameter int AW = 14,
    parameter int FW = 16
) ();
    logic             buf_we_i;
    logic [AW-1:0]    buf_addr_i;
    logic [DW-1:0]    buf_wdata_i;
    logic             trig_i;
    logic [AW+FW-1:0] set_size_i;
    logic [AW+FW-1:0] set_step_i;
    logic [AW-1:0]    set_ofs_i;
    logic [15:0]      set_ncyc_i;
    logic             set_wrap_i;
    logic             set_interp_i;
    logic [DW-1:0]    set_amp_i;
    logic [DW-1:0]    set_dc_i;
    logic [DW-1:0]    set_last_i;
    logic             set_zero_i;
    logic             set_rst_i;
    logic [DW-1:0]    dac_o;
    logic             busy_o;
    logic             done_o;
    logic [AW-1:0]    buf_rpnt_o;

    modport master (
        output buf_we_i, buf_addr_i, buf_wdata_i, trig_i,
               set_size_i, set_step_i, set_ofs_i, set_ncyc_i, set_wrap_i,
               set_interp_i, set_amp_i, set_dc_i, set_last_i, set_zero_i,
               set_rst_i,
        input  dac_o, busy_o, done_o, buf_rpnt_o
    );

    modport slave (
        input  buf_we_i, buf_addr_i, buf_wdata_i, trig_i,
               set_size_i, set_step_i, set_ofs_i, set_ncyc_i, set_wrap_i,
               set_interp_i, set_amp_i, set_dc_i, set_last_i, set_zero_i,
               set_rst_i,
        output dac_o, busy_o, done_o, buf_rpnt_o
    );
endinterface

// File: rtl/asg_ch_interp.sv
// asg_ch_interp: arbitrary-signal-generator channel with a fractional table
// pointer, optional linear interpolation between adjacent samples, gain,
// offset and saturation, feeding one DAC.
// Ports:
//   dac_clk_i  sole clock (table writes and DAC path)
//   dac_rst_i  asynchronous active-high reset
//   bus        asg_ch_interp_if.slave: table write port, trigger, settings,
//              dac_o / busy_o / done_o / buf_rpnt_o status
// Pointer update to dac_o is 7 cycles.
module asg_ch_interp #(
    parameter int DW = 14,
    parameter int AW = 14,
    parameter int FW = 16,
    parameter int IW = 8
) (
    input logic            dac_clk_i,
    input logic            dac_rst_i,
    asg_ch_interp_if.slave bus
);
    localparam int PW = AW + FW;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [PW-1:0] pnt;
    logic [15:0]   cyc_cnt;
    logic          last_flag;
    logic          busy_r;
    logic          done_r;

    // ---------------- pointer / burst control ----------------
    logic [PW:0]   npnt;
    logic [PW:0]   pnt_rem;
    logic          wrap_hit;
    logic [PW-1:0] pnt_start;

    assign npnt      = {1'b0, pnt} + {1'b0, bus.set_step_i};
    assign wrap_hit  = npnt > {1'b0, bus.set_size_i};
    assign pnt_rem   = npnt - {1'b0, bus.set_size_i} - (PW+1)'(1);
    assign pnt_start = {bus.set_ofs_i, {FW{1'b0}}};

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state     <= IDLE;
            pnt       <= '0;
            cyc_cnt   <= '0;
            last_flag <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.set_rst_i) begin
                state     <= IDLE;
                busy_r    <= 1'b0;
                pnt       <= pnt_start;
                last_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.trig_i) begin
                            state     <= RUN;
                            busy_r    <= 1'b1;
                            pnt       <= pnt_start;
                            cyc_cnt   <= bus.set_ncyc_i;
                            last_flag <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (wrap_hit) begin
                            if (cyc_cnt == 16'd1) begin
                                state     <= IDLE;
                                busy_r    <= 1'b0;
                                done_r    <= 1'b1;
                                last_flag <= 1'b1;
                                pnt       <= pnt_start;
                            end else begin
                                // wrap=1 keeps the phase remainder past size
                                pnt <= bus.set_wrap_i ? pnt_rem[PW-1:0] : pnt_start;
                                // cyc_cnt == 0 is continuous mode
                                if (cyc_cnt != 16'd0)
                                    cyc_cnt <= cyc_cnt - 16'd1;
                            end
                        end else begin
                            pnt <= npnt[PW-1:0];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ---------------- table storage ----------------
    // Two copies so the current sample and its successor read in one cycle.
    logic [DW-1:0] ram_a [0:(1<<AW)-1];
    logic [DW-1:0] ram_b [0:(1<<AW)-1];

    always_ff @(posedge dac_clk_i) begin
        if (bus.buf_we_i) begin
            ram_a[bus.buf_addr_i] <= bus.buf_wdata_i;
            ram_b[bus.buf_addr_i] <= bus.buf_wdata_i;
        end
    end

    // ---------------- data pipeline ----------------
    logic [AW-1:0] addr, addr_nx;
    assign addr    = pnt[PW-1:FW];
    // successor of the last table entry is the start address
    assign addr_nx = (addr == bus.set_size_i[PW-1:FW]) ? bus.set_ofs_i : addr + AW'(1);

    logic [AW-1:0]            addr_r, addr_nx_r;
    logic [IW-1:0]            f1, f2, f3;
    logic signed [DW-1:0]     a2, b2, a3, a4, y5;
    logic signed [DW:0]       d3;
    logic signed [DW+IW+1:0]  p4;
    logic signed [DW:0]       m6;
    logic [DW-1:0]            dac_r;
    logic [5:0]               last_pipe;

    logic signed [2*DW:0]     prod6;
    logic signed [DW+1:0]     s7;
    logic [DW-1:0]            s7_sat;

    assign prod6 = (2*DW+1)'(y5) * (2*DW+1)'($signed({1'b0, bus.set_amp_i}));
    assign s7    = {m6[DW], m6} + {{2{bus.set_dc_i[DW-1]}}, bus.set_dc_i};

    // in range iff the three top bits agree; otherwise clamp by sign
    always_comb begin
        s7_sat = s7[DW-1:0];
        if (s7[DW+1:DW-1] != 3'b000 && s7[DW+1:DW-1] != 3'b111)
            s7_sat = s7[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            addr_r    <= '0;
            addr_nx_r <= '0;
            f1        <= '0;
            f2        <= '0;
            f3        <= '0;
            a2        <= '0;
            b2        <= '0;
            a3        <= '0;
            d3        <= '0;
            a4        <= '0;
            p4        <= '0;
            y5        <= '0;
            m6        <= '0;
            dac_r     <= '0;
            last_pipe <= '0;
        end else begin
            // 1: address and weight
            addr_r    <= addr;
            addr_nx_r <= addr_nx;
            f1        <= pnt[FW-1 -: IW];
            // 2: table read (old data on a same-address write)
            a2        <= ram_a[addr_r];
            b2        <= ram_b[addr_nx_r];
            f2        <= f1;
            // 3: difference
            d3        <= {b2[DW-1], b2} - {a2[DW-1], a2};
            a3        <= a2;
            f3        <= f2;
            // 4: weighted difference
            p4        <= (DW+IW+2)'(d3) * (DW+IW+2)'($signed({1'b0, f3}));
            a4        <= a3;
            // 5: interpolated sample; result lies between a and b so fits DW
            y5        <= bus.set_interp_i ? a4 + DW'(p4 >>> IW) : a4;
            // 6: gain, unity at 2^(DW-1)
            m6        <= (DW+1)'(prod6 >>> (DW-1));
            // 7: offset, saturate, output select
            if (bus.set_zero_i)
                dac_r <= '0;
            else if (last_pipe[5])
                dac_r <= bus.set_last_i;
            else
                dac_r <= s7_sat;
            // last_flag aligned so the final burst sample still reaches dac_o
            last_pipe <= {last_pipe[4:0], last_flag};
        end
    end

    assign bus.dac_o      = dac_r;
    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
    assign bus.buf_rpnt_o = addr_r;
endmodule

// File: tb/tb_asg_ch_interp.sv
// tb_asg_ch_interp: directed bench for asg_ch_interp. Steady-state scaling and
// saturation come from a vector table; bursts, interpolation, wrap, continuous
// mode, abort and reset mid-burst are hand-written sequences.
module tb_asg_ch_interp;
    localparam int DW = 14;
    localparam int AW = 14;
    localparam int FW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    asg_ch_interp_if #(.DW(DW), .AW(AW), .FW(FW)) bus ();

    asg_ch_interp #(.DW(DW), .AW(AW), .FW(FW), .IW(8)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always @(negedge clk) if (bus.done_o) done_cnt++;

    typedef struct {
        int v;
        int amp;
        int dc;
        bit zero;
        int exp;
    } scale_vec_t;

    scale_vec_t sv [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int dac_s();
        return int'($signed(bus.dac_o));
    endfunction

    task automatic wr(input int addr, input int data);
        bus.buf_addr_i  = AW'(addr);
        bus.buf_wdata_i = DW'(data);
        bus.buf_we_i    = 1'b1;
        tick();
        bus.buf_we_i    = 1'b0;
    endtask

    task automatic cfg(input int size, input int step, input int ofs,
                       input int ncyc, input bit wrap, input bit interp);
        bus.set_size_i   = 30'(size);
        bus.set_step_i   = 30'(step);
        bus.set_ofs_i    = AW'(ofs);
        bus.set_ncyc_i   = 16'(ncyc);
        bus.set_wrap_i   = wrap;
        bus.set_interp_i = interp;
    endtask

    task automatic trigger();
        bus.trig_i = 1'b1;
        tick();
        bus.trig_i = 1'b0;
    endtask

    initial begin
        int d0;
        int ei [2][5] = '{'{0, 250, 500, 750, 1000}, '{0, 0, 0, 0, 1000}};
        int ew [2][6] = '{'{0, 3, 6, 9, 2, 5}, '{0, 3, 6, 9, 0, 3}};

        sv[0] = '{8191, 16383, 100, 1'b0, 8191};
        sv[1] = '{-8192, 16383, -100, 1'b0, -8192};
        sv[2] = '{1000, 8192, 0, 1'b0, 1000};
        sv[3] = '{1000, 4096, -50, 1'b0, 450};
        sv[4] = '{-1000, 4096, 0, 1'b0, -500};
        sv[5] = '{-3, 4096, 0, 1'b0, -2};
        sv[6] = '{8191, 8192, 1, 1'b0, 8191};
        sv[7] = '{100, 0, 7, 1'b0, 7};
        sv[8] = '{500, 8192, 0, 1'b1, 0};
        sv[9] = '{-8192, 8192, 0, 1'b0, -8192};

        bus.buf_we_i = 1'b0; bus.buf_addr_i = '0; bus.buf_wdata_i = '0;
        bus.trig_i = 1'b0; bus.set_rst_i = 1'b0; bus.set_zero_i = 1'b0;
        bus.set_amp_i = 14'd8192; bus.set_dc_i = '0; bus.set_last_i = '0;
        cfg(255 << 16, 1 << 16, 0, 1, 1'b0, 1'b0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dac", dac_s(), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_rpnt", int'(bus.buf_rpnt_o), 0);
        rst = 1'b0;
        tick();

        // steady-state scale / offset / saturation on table[0] while idle
        for (int i = 0; i < 10; i++) begin
            wr(0, sv[i].v);
            bus.set_amp_i  = DW'(sv[i].amp);
            bus.set_dc_i   = DW'(sv[i].dc);
            bus.set_zero_i = sv[i].zero;
            repeat (9) tick();
            chk($sformatf("scale%0d", i), dac_s(), sv[i].exp);
        end
        bus.set_zero_i = 1'b0;
        bus.set_amp_i  = 14'd8192;
        bus.set_dc_i   = '0;

        // ramp table, single pass
        bus.buf_we_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.buf_addr_i  = AW'(i);
            bus.buf_wdata_i = DW'(i * 4);
            tick();
        end
        bus.buf_we_i = 1'b0;
        cfg(255 << 16, 1 << 16, 0, 1, 1'b0, 1'b0);
        bus.set_last_i = DW'(1234);
        d0 = done_cnt;
        trigger();
        chk("ramp_busy_rise", int'(bus.busy_o), 1);
        repeat (7) tick();
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("ramp%0d", i), dac_s(), i * 4);
            tick();
        end
        chk("ramp_last", dac_s(), 1234);
        chk("ramp_busy_fall", int'(bus.busy_o), 0);
        chk("ramp_done_once", done_cnt - d0, 1);

        // set_zero acts one cycle after assertion
        bus.set_zero_i = 1'b1;
        tick();
        chk("zero_on", dac_s(), 0);
        bus.set_zero_i = 1'b0;
        tick();
        chk("zero_off", dac_s(), 1234);

        // interpolation on / off
        wr(0, 0);
        wr(1, 1000);
        bus.set_last_i = DW'(-77);
        for (int r = 0; r < 2; r++) begin
            cfg(1 << 16, 1 << 14, 0, 1, 1'b0, (r == 0));
            trigger();
            repeat (7) tick();
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("interp%0d_%0d", r, k), dac_s(), ei[r][k]);
                tick();
            end
            chk($sformatf("interp%0d_last", r), dac_s(), -77);
        end

        // wrap with and without remainder, then abort
        for (int r = 0; r < 2; r++) begin
            cfg((10 << 16) - 1, 3 << 16, 0, 0, (r == 0), 1'b0);
            trigger();
            tick();
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("wrap%0d_%0d", r, k), int'(bus.buf_rpnt_o), ew[r][k]);
                tick();
            end
            bus.set_rst_i = 1'b1;
            tick();
            bus.set_rst_i = 1'b0;
            chk($sformatf("wrap%0d_abort", r), int'(bus.busy_o), 0);
        end

        // continuous mode: >1000 passes, no done
        cfg((4 << 16) - 1, 1 << 16, 0, 0, 1'b0, 1'b0);
        d0 = done_cnt;
        trigger();
        repeat (4100) tick();
        chk("cont_busy", int'(bus.busy_o), 1);
        chk("cont_no_done", done_cnt - d0, 0);
        bus.set_rst_i = 1'b1;
        tick();
        bus.set_rst_i = 1'b0;
        chk("cont_abort", int'(bus.busy_o), 0);
        // set_rst beats a simultaneous trigger
        bus.set_rst_i = 1'b1;
        bus.trig_i    = 1'b1;
        tick();
        bus.set_rst_i = 1'b0;
        bus.trig_i    = 1'b0;
        chk("rst_trig_idle0", int'(bus.busy_o), 0);
        repeat (3) tick();
        chk("rst_trig_idle1", int'(bus.busy_o), 0);
        chk("abort_no_done", done_cnt - d0, 0);

        // reset mid-burst, then restart from ofs
        cfg(255 << 16, 1 << 16, 0, 1, 1'b0, 1'b0);
        d0 = done_cnt;
        trigger();
        repeat (20) tick();
        chk("mid_sample", dac_s(), 52);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dac", dac_s(), 0);
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        tick();
        rst = 1'b0;
        cfg(255 << 16, 1 << 16, 5, 1, 1'b0, 1'b0);
        tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        trigger();
        chk("restart_busy", int'(bus.busy_o), 1);
        tick();
        chk("restart_rpnt", int'(bus.buf_rpnt_o), 5);
        repeat (6) tick();
        chk("restart_dac", dac_s(), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
